// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl: job sequencer for a gray_counter datapath.
// Accepts a job (gray start value, direction, step count), drives the
// counter's select / parallel-load inputs through LOAD, RUN and DONE, and
// checks the counter's gray feedback against an internal binary shadow.
module gray_counter_ctrl #(
  parameter int n = 3,
  parameter int w = 8
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic         in_start,
  input  logic         in_dir,
  input  logic [n-1:0] in_load_val,
  input  logic [w-1:0] in_steps,
  input  logic         in_abort,
  input  logic [n-1:0] in_g,
  output logic [1:0]   ou_sel,
  output logic [n-1:0] ou_p,
  output logic         ou_busy,
  output logic         ou_done,
  output logic         ou_abrt,
  output logic         ou_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Counter select encodings as seen by gray_counter.in_sel.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_UP   = 2'b11;
  localparam logic [1:0] SEL_DN   = 2'b01;

  localparam logic [n-1:0] shadow_one_c = {{(n-1){1'b0}}, 1'b1};
  localparam logic [w-1:0] steps_zero_c = {w{1'b0}};
  localparam logic [w-1:0] steps_one_c  = {{(w-1){1'b0}}, 1'b1};

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [n-1:0] gray_to_bin(input logic [n-1:0] g);
    logic [n-1:0] b;
    b[n-1] = g[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to gray.
  function automatic logic [n-1:0] bin_to_gray(input logic [n-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t         state_r;
  logic [1:0]     sel_r;
  logic [n-1:0]   p_r;
  logic           busy_r;
  logic           done_r;
  logic           abrt_r;
  logic           err_r;
  logic           dir_r;
  logic [n-1:0]   shadow_r;
  logic [w-1:0]   remaining_r;

  logic [n-1:0]   shadow_gray_s;
  logic           check_en_s;
  logic           mismatch_s;
  logic [n-1:0]   shadow_step_s;

  // Feedback check: the counter is only expected to track the shadow once loaded.
  always_comb begin
    shadow_gray_s = bin_to_gray(shadow_r);
    check_en_s    = (state_r == ST_RUN) || (state_r == ST_DONE);
    mismatch_s    = (in_g != shadow_gray_s);
    if (dir_r) begin
      shadow_step_s = shadow_r + shadow_one_c;
    end else begin
      shadow_step_s = shadow_r - shadow_one_c;
    end
  end

  // Sequencer FSM with all outputs, shadow and step counter registered.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= SEL_HOLD;
      p_r         <= {n{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      abrt_r      <= 1'b0;
      err_r       <= 1'b0;
      dir_r       <= 1'b0;
      shadow_r    <= {n{1'b0}};
      remaining_r <= {w{1'b0}};
    end else begin
      done_r <= 1'b0;
      abrt_r <= 1'b0;
      // Sticky: a later start is the only thing that clears it.
      if (check_en_s && mismatch_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          sel_r  <= SEL_HOLD;
          busy_r <= 1'b0;
          // A simultaneous abort is ignored here, so start wins.
          if (in_start) begin
            state_r     <= ST_LOAD;
            sel_r       <= SEL_LOAD;
            p_r         <= in_load_val;
            dir_r       <= in_dir;
            remaining_r <= in_steps;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // The counter takes ou_p on this same edge.
          shadow_r <= gray_to_bin(p_r);
          if (in_abort) begin
            state_r <= ST_IDLE;
            sel_r   <= SEL_HOLD;
            busy_r  <= 1'b0;
            abrt_r  <= 1'b1;
          end else if (remaining_r == steps_zero_c) begin
            state_r <= ST_DONE;
            sel_r   <= SEL_HOLD;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            sel_r   <= dir_r ? SEL_UP : SEL_DN;
          end
        end
        ST_RUN: begin
          // The counter steps on every RUN edge; the shadow follows it.
          shadow_r    <= shadow_step_s;
          remaining_r <= remaining_r - steps_one_c;
          if (in_abort) begin
            state_r <= ST_IDLE;
            sel_r   <= SEL_HOLD;
            busy_r  <= 1'b0;
            abrt_r  <= 1'b1;
          end else if (remaining_r == steps_one_c) begin
            state_r <= ST_DONE;
            sel_r   <= SEL_HOLD;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          sel_r   <= SEL_HOLD;
          busy_r  <= 1'b0;
          if (in_abort) begin
            abrt_r <= 1'b1;
          end else begin
            abrt_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sel_r   <= SEL_HOLD;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ou_sel  = sel_r;
  assign ou_p    = p_r;
  assign ou_busy = busy_r;
  assign ou_done = done_r;
  assign ou_abrt = abrt_r;
  assign ou_err  = err_r;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Bench for gray_counter_ctrl: an ideal gray counter closes the loop, and a
// job-level model (phase index since accept) predicts every output.
module tb_gray_counter_ctrl;

  localparam int N = 3;
  localparam int W = 8;
  localparam int MOD = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dir;
  logic         abort;
  logic [N-1:0] load_val;
  logic [W-1:0] steps;
  logic [N-1:0] in_g;
  logic [N-1:0] fault;
  logic [1:0]   sel;
  logic [N-1:0] p;
  logic         busy;
  logic         done;
  logic         abrt;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_counter_ctrl #(.n(N), .w(W)) dut (
    .in_clk     (clk),
    .rst        (rst),
    .in_start   (start),
    .in_dir     (dir),
    .in_load_val(load_val),
    .in_steps   (steps),
    .in_abort   (abort),
    .in_g       (in_g),
    .ou_sel     (sel),
    .ou_p       (p),
    .ou_busy    (busy),
    .ou_done    (done),
    .ou_abrt    (abrt),
    .ou_err     (err)
  );

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal gray counter driven by the DUT; fault XORs errors onto its feedback.
  logic [N-1:0] cnt_r = '0;
  logic [N-1:0] cnt_g;
  always @(posedge clk) begin
    case (sel)
      2'b10:   cnt_r <= g2b(p);
      2'b11:   cnt_r <= cnt_r + 1'b1;
      2'b01:   cnt_r <= cnt_r - 1'b1;
      default: cnt_r <= cnt_r;
    endcase
  end
  assign cnt_g = cnt_r ^ (cnt_r >> 1);
  assign in_g  = cnt_g ^ fault;

  // Job model: m_t counts edges since accept (0 = load, 1..steps = run, steps+1 = done).
  logic         m_active, m_dir, m_err, m_abrt;
  int           m_t, m_steps;
  logic [N-1:0] m_load;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_dir <= 1'b0; m_err <= 1'b0; m_abrt <= 1'b0;
      m_t <= 0; m_steps <= 0; m_load <= '0;
    end else if (!m_active) begin
      m_abrt <= 1'b0;
      if (start) begin
        m_active <= 1'b1; m_t <= 0; m_steps <= int'(steps);
        m_dir <= dir; m_load <= load_val; m_err <= 1'b0;
      end
    end else begin
      m_abrt <= abort;
      if (m_t >= 1 && fault != '0) m_err <= 1'b1;
      if (abort || m_t == m_steps + 1) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  function automatic logic [1:0] exp_sel();
    if (!m_active) return 2'b00;
    if (m_t == 0) return 2'b10;
    if (m_t <= m_steps) return m_dir ? 2'b11 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [N-1:0] exp_gray();
    int v;
    logic [N-1:0] b;
    v = int'(g2b(m_load));
    v = m_dir ? v + (m_t - 1) : v - (m_t - 1);
    v = ((v % MOD) + MOD) % MOD;
    b = N'(v);
    return b ^ (b >> 1);
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("sel",  sel,  exp_sel());
    check("p",    p,    m_load);
    check("busy", busy, m_active);
    check("done", done, m_active && (m_t == m_steps + 1));
    check("abrt", abrt, m_abrt);
    check("err",  err,  m_err);
    if (m_active && m_t >= 1) check("gray_seq", cnt_g, exp_gray());
  end

  task automatic start_job(input logic [N-1:0] l, input logic d, input logic [W-1:0] s);
    start = 1'b1; load_val = l; dir = d; steps = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [1:0]   s1 [5];
  logic [N-1:0] g1 [5];
  logic [1:0]   s2 [4];
  logic [N-1:0] g2 [4];

  initial begin
    s1 = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    g1 = '{3'b000, 3'b111, 3'b101, 3'b100, 3'b000};
    s2 = '{2'b10, 2'b01, 2'b01, 2'b00};
    g2 = '{3'b000, 3'b000, 3'b100, 3'b101};
    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    load_val = '0; steps = '0; fault = '0;
    repeat (2) @(negedge clk);
    check("rst_sel", sel, 2'b00); check("rst_p", p, 3'b000);
    check("rst_busy", busy, 1'b0); check("rst_done", done, 1'b0);
    check("rst_abrt", abrt, 1'b0); check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Up count from 111, three steps.
    start_job(3'b111, 1'b1, 8'd3);
    for (int k = 0; k < 5; k++) begin
      check("t1_sel", sel, s1[k]);
      if (k > 0) check("t1_g", in_g, g1[k]);
      check("t1_done", done, k == 4);
      check("t1_busy", busy, 1'b1);
      @(negedge clk);
    end
    check("t1_idle", busy, 1'b0); check("t1_err", err, 1'b0);

    // Down count with wrap from 000.
    start_job(3'b000, 1'b0, 8'd2);
    for (int k = 0; k < 4; k++) begin
      check("t2_sel", sel, s2[k]);
      if (k > 0) check("t2_g", in_g, g2[k]);
      check("t2_done", done, k == 3);
      @(negedge clk);
    end
    check("t2_idle", busy, 1'b0); check("t2_err", err, 1'b0);

    // Zero steps: LOAD goes straight to DONE.
    start_job(3'b011, 1'b1, 8'd0);
    check("t3_sel0", sel, 2'b10); check("t3_done0", done, 1'b0);
    @(negedge clk);
    check("t3_sel1", sel, 2'b00); check("t3_done1", done, 1'b1);
    check("t3_g", in_g, 3'b011);
    @(negedge clk);
    check("t3_idle", busy, 1'b0); check("t3_done2", done, 1'b0);

    // Abort on the second RUN cycle, then a normal job.
    start_job(3'b010, 1'b1, 8'd5);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_sel", sel, 2'b00); check("ab_abrt", abrt, 1'b1);
    check("ab_done", done, 1'b0); check("ab_busy", busy, 1'b0);
    @(negedge clk);
    check("ab_abrt_end", abrt, 1'b0); check("ab_done_end", done, 1'b0);
    start_job(3'b001, 1'b0, 8'd1);
    @(negedge clk);
    @(negedge clk);
    check("ab_next_done", done, 1'b1);
    @(negedge clk);
    check("ab_next_idle", busy, 1'b0);

    // One corrupted feedback cycle: sticky error until next start.
    start_job(3'b101, 1'b0, 8'd4);
    @(negedge clk);
    fault = 3'b010;
    @(negedge clk);
    fault = '0;
    check("er_set", err, 1'b1);
    repeat (3) @(negedge clk);
    check("er_done", done, 1'b1); check("er_in_done", err, 1'b1);
    @(negedge clk);
    check("er_idle_busy", busy, 1'b0); check("er_idle", err, 1'b1);
    start_job(3'b000, 1'b1, 8'd2);
    check("er_clear", err, 1'b0);
    repeat (4) @(negedge clk);
    check("er_clear_idle", err, 1'b0); check("er_clear_busy", busy, 1'b0);

    // Start while busy is ignored; original job finishes on time.
    start_job(3'b001, 1'b1, 8'd3);
    start = 1'b1; load_val = 3'b110; steps = 8'd9; dir = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("bz_done", done, 1'b1); check("bz_p", p, 3'b001);
    @(negedge clk);
    check("bz_idle", busy, 1'b0);

    // Asynchronous reset mid-RUN clears everything without a clock edge.
    start_job(3'b100, 1'b1, 8'd10);
    @(negedge clk);
    fault = 3'b001;
    @(negedge clk);
    fault = '0;
    check("rs_err_pre", err, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rs_sel", sel, 2'b00); check("rs_p", p, 3'b000);
    check("rs_busy", busy, 1'b0); check("rs_done", done, 1'b0);
    check("rs_abrt", abrt, 1'b0); check("rs_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Long job with many wraps.
    start_job(3'b110, 1'b0, 8'd255);
    repeat (255) @(negedge clk);
    check("lg_done_early", done, 1'b0);
    @(negedge clk);
    check("lg_done", done, 1'b1); check("lg_g", in_g, 3'b111);
    @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 4) == 0;
      abort    = ($urandom % 16) == 0;
      dir      = 1'($urandom);
      load_val = N'($urandom);
      steps    = (($urandom % 8) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(0, 20));
      fault    = (($urandom % 32) == 0) ? N'($urandom_range(1, 7)) : '0;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; fault = '0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
